// File: rtl/misr_pkg.sv
// Shared types and the Galois MISR update function used by misr_core.
package misr_pkg;

  // Widest signature the update function handles; narrower instances use the low bits.
  localparam int unsigned MISR_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } misr_state_e;

  // Bits at and above `width` are returned as zero.
  function automatic logic [MISR_MAX_W-1:0] misr_next(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] din,
    input logic [MISR_MAX_W-1:0] poly,
    input int                    width,
    input int                    channels
  );
    logic [MISR_MAX_W-1:0] nxt;
    logic                  m;
    nxt    = '0;
    m      = sig[width-1];
    nxt[0] = din[0] ^ m;
    for (int k = 1; k < MISR_MAX_W; k++) begin
      if (k < width) begin
        nxt[k] = sig[k-1] ^ (poly[k] & m) ^ ((k < channels) ? din[k] : 1'b0);
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/misr_core.sv
// Signature register with Galois LFSR update; load takes priority over en.
module misr_core
  import misr_pkg::*;
#(
  parameter int unsigned          WIDTH    = 4,
  parameter int unsigned          CHANNELS = 1,
  parameter logic [WIDTH-1:0]     POLY     = 4'b0011
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [WIDTH-1:0]    seed,
  input  logic                en,
  input  logic [CHANNELS-1:0] din,
  output logic [WIDTH-1:0]    sig,
  output logic [WIDTH-1:0]    sig_nxt
);

  logic [WIDTH-1:0]      sig_q;
  logic [WIDTH-1:0]      sig_d;
  logic [MISR_MAX_W-1:0] upd;

  // The top needs the post-beat value to judge match in the same cycle.
  always_comb begin
    upd     = misr_next(MISR_MAX_W'(sig_q), MISR_MAX_W'(din), MISR_MAX_W'(POLY),
                        WIDTH, CHANNELS);
    sig_nxt = upd[WIDTH-1:0];
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = seed;
    end else if (en) begin
      sig_d = sig_nxt;
    end
  end

  // NOTE: reset is synchronous and checked first, so it overrides load and en on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      // NOTE: non-blocking assignment for state so all flops update from pre-edge values.
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/misr_sig.sv
// MISR with run control: FSM, beat counter, len/golden capture and match flag.
module misr_sig
  import misr_pkg::*;
#(
  parameter int unsigned      WIDTH    = 4,
  parameter int unsigned      CHANNELS = 1,
  parameter logic [WIDTH-1:0] POLY     = 4'b0011,
  parameter logic [WIDTH-1:0] SEED     = '0,
  parameter int unsigned      CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-1:0]    len,
  input  logic [WIDTH-1:0]    golden,
  input  logic                din_valid,
  input  logic [CHANNELS-1:0] din,
  output logic [WIDTH-1:0]    sig,
  output logic                busy,
  output logic                done,
  output logic                match
);

  misr_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [WIDTH-1:0] golden_q, golden_d;
  logic             match_q, match_d;
  logic [WIDTH-1:0] sig_nxt;
  logic             beat;

  // start wins over a same-cycle beat, so an aborted run never absorbs it.
  assign beat = (state_q == ST_RUN) && din_valid && !start;

  misr_core #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .POLY     (POLY)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (start),
    .seed    (SEED),
    .en      (beat),
    .din     (din),
    .sig     (sig),
    .sig_nxt (sig_nxt)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    golden_d = golden_q;
    match_d  = match_q;
    if (start) begin
      cnt_d    = '0;
      len_d    = len;
      golden_d = golden;
      if (len == '0) begin
        state_d = ST_DONE;
        match_d = (SEED == golden);
      end else begin
        state_d = ST_RUN;
        match_d = 1'b0;
      end
    end else if (beat) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == len_q - 1'b1) begin
        state_d = ST_DONE;
        match_d = (sig_nxt == golden_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      golden_q <= '0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      golden_q <= golden_d;
      match_q  <= match_d;
    end
  end

  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign match = match_q;

endmodule
